// File: rtl/aes_cfg_pkg.sv
// Shared constants and FSM state type for the AES config frame loader.
// Parity state is present only when CONFIG_FRAME_PARITY_EN is defined.
package aes_cfg_pkg;

  localparam int FRAME_BITS_DEFAULT = 137;
  localparam int KEY_BITS = 128;
  localparam int ADDR_BITS = 8;
  localparam int MODE_BITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_VALID = 2'd2
`ifdef CONFIG_FRAME_PARITY_EN
    ,
    ST_PARITY = 2'd3
`endif
  } cfg_state_e;

endpackage

// File: rtl/frame_bit_counter.sv
// Payload bit counter: clear, enable, saturating count, last-bit flag.
// Ports: clk, n_rst, clear, enable -> count, at_last.
module frame_bit_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 137
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             at_last
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
  localparam logic [WIDTH-1:0] TOP  = WIDTH'(LIMIT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TOP)) begin
      count <= count + WIDTH'(1);
    end
  end

  // Flags the cycle in which the final payload bit is shifted.
  assign at_last = enable && (count == LAST);

endmodule

// File: rtl/config_frame_ctrl.sv
// Serial config frame controller feeding the AES key/addr/mode shifter.
// Ports: clk, n_rst, start, abort, serial_in, cfg_ready -> shift_enable,
// bit_count, cfg_valid, frame_done, cfg_err. Macro: CONFIG_FRAME_PARITY_EN.
module config_frame_ctrl
  import aes_cfg_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       abort,
  input  logic       serial_in,
  output logic       shift_enable,
  output logic [7:0] bit_count,
  output logic       cfg_valid,
  input  logic       cfg_ready,
  output logic       frame_done,
  output logic       cfg_err
);

  cfg_state_e state;
  logic       at_last;
  logic       handshake;
  logic       par_fail;
  logic       cnt_clear;
  logic       cnt_en;

  assign handshake  = (state == ST_VALID) && cfg_ready && !abort;
  assign frame_done = handshake;

`ifdef CONFIG_FRAME_PARITY_EN
  logic par_acc;
  // Even parity: payload XOR plus parity bit must be zero.
  assign par_fail = (state == ST_PARITY) && (par_acc ^ serial_in) && !abort;
  assign cfg_err  = par_fail;
`else
  logic unused_serial;
  assign unused_serial = serial_in;
  assign par_fail      = 1'b0;
  assign cfg_err       = 1'b0;
`endif

  // Counter is held at zero in IDLE so a new frame always starts at 0.
  assign cnt_clear = abort || handshake || par_fail || (state == ST_IDLE);
  assign cnt_en    = (state == ST_SHIFT);

  frame_bit_counter #(
    .WIDTH (8),
    .LIMIT (FRAME_BITS)
  ) u_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .count   (bit_count),
    .at_last (at_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      shift_enable <= 1'b0;
      cfg_valid    <= 1'b0;
`ifdef CONFIG_FRAME_PARITY_EN
      par_acc      <= 1'b0;
`endif
    end else if (abort) begin
      state        <= ST_IDLE;
      shift_enable <= 1'b0;
      cfg_valid    <= 1'b0;
`ifdef CONFIG_FRAME_PARITY_EN
      par_acc      <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_SHIFT;
            shift_enable <= 1'b1;
`ifdef CONFIG_FRAME_PARITY_EN
            par_acc      <= 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
`ifdef CONFIG_FRAME_PARITY_EN
          par_acc <= par_acc ^ serial_in;
`endif
          if (at_last) begin
            shift_enable <= 1'b0;
`ifdef CONFIG_FRAME_PARITY_EN
            state        <= ST_PARITY;
`else
            state        <= ST_VALID;
            cfg_valid    <= 1'b1;
`endif
          end
        end
`ifdef CONFIG_FRAME_PARITY_EN
        ST_PARITY: begin
          if (par_fail) begin
            state <= ST_IDLE;
          end else begin
            state     <= ST_VALID;
            cfg_valid <= 1'b1;
          end
        end
`endif
        ST_VALID: begin
          if (cfg_ready) begin
            state     <= ST_IDLE;
            cfg_valid <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          shift_enable <= 1'b0;
          cfg_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule
